// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy states, per-stage payload widths and bubble encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipeState_e;

    localparam int IFID_W  = 64;
    localparam int IDEX_W  = 160;
    localparam int EXMEM_W = 128;
    localparam int MEMWB_W = 104;

    // addi x0, x0, 0 -- the canonical NOP placed in the instruction field of a bubble
    localparam logic [31:0]       NOP_INSN    = 32'h0000_0013;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {32'h0000_0000, NOP_INSN};

    function automatic logic stageValid(input pipeState_e s);
        return s != EMPTY;
    endfunction

    function automatic logic stageReady(input pipeState_e s);
        return s != FULL;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with valid/ready handshake and a 2-entry skid buffer; ready is registered.
// Define PIPE_STAGE_STATS_EN to add saturating STALL_CNT / FLUSH_CNT outputs.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = IFID_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
`endif
);

    pipeState_e        stateReg;
    logic [DATA_W-1:0] mainReg;
    logic [DATA_W-1:0] skidReg;
    logic              inFire;
    logic              outFire;

    // Both handshake outputs depend only on the state register, so no ready path is combinational.
    assign OUT_VALID = stageValid(stateReg);
    assign IN_READY  = stageReady(stateReg);
    assign OUT_DATA  = mainReg;

    assign inFire  = IN_VALID & IN_READY;
    assign outFire = OUT_VALID & OUT_READY;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            stateReg <= EMPTY;
            mainReg  <= BUBBLE_VAL;
            skidReg  <= '0;
        end else if (FLUSH) begin
            // Any concurrent out_fire has already been honoured by downstream; incoming data is dropped.
            stateReg <= EMPTY;
            mainReg  <= BUBBLE_VAL;
            skidReg  <= '0;
        end else begin
            case (stateReg)
                EMPTY: begin
                    if (inFire) begin
                        mainReg  <= IN_DATA;
                        stateReg <= BUSY;
                    end
                end
                BUSY: begin
                    if (inFire && outFire) begin
                        mainReg <= IN_DATA;
                    end else if (inFire) begin
                        skidReg  <= IN_DATA;
                        stateReg <= FULL;
                    end else if (outFire) begin
                        mainReg  <= BUBBLE_VAL;
                        stateReg <= EMPTY;
                    end
                end
                FULL: begin
                    if (outFire) begin
                        mainReg  <= skidReg;
                        stateReg <= BUSY;
                    end
                end
                default: begin
                    stateReg <= EMPTY;
                    mainReg  <= BUBBLE_VAL;
                    skidReg  <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) stallCounter (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .inc   (OUT_VALID & ~OUT_READY),
        .count (STALL_CNT)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) flushCounter (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .inc   (FLUSH),
        .count (FLUSH_CNT)
    );
`else
    // Keeps the counter width parameter referenced when the statistics are compiled out.
    if (CNT_W < 1) begin : gCntWidthGuard
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid; also checks the statistics counters when PIPE_STAGE_STATS_EN is set.
module tb_pipe_stage_skid;

    localparam int                DW     = 16;
    localparam logic [DW-1:0]     BUBBLE = 16'h0013;
    localparam int                CW     = 3;
    localparam logic [CW-1:0]     CMAX   = '1;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [DW-1:0] IN_DATA = '0;
    logic          FLUSH = 1'b0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [DW-1:0] OUT_DATA;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] STALL_CNT;
    logic [CW-1:0] FLUSH_CNT;
`endif

    int            cmpCnt = 0;
    int            misCnt = 0;
    logic [DW-1:0] sbQ[$];
    logic [CW-1:0] stallModel = '0;
    logic [CW-1:0] flushModel = '0;
    bit            acc;

    always #5 CLOCK = ~CLOCK;

    pipe_stage_skid #(
        .DATA_W     (DW),
        .BUBBLE_VAL (BUBBLE),
        .CNT_W      (CW)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .FLUSH     (FLUSH),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .STALL_CNT (STALL_CNT),
        .FLUSH_CNT (FLUSH_CNT)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            misCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model the edge from the inputs currently driven, advance one clock, then check outputs.
    task automatic cycle(output bit accepted);
        bit mValid, mReady, inF, outF;
        logic [DW-1:0] exp;
        mValid = (sbQ.size() != 0);
        mReady = (sbQ.size() < 2);
        inF  = IN_VALID && mReady;
        outF = mValid && OUT_READY;
        if (mValid && !OUT_READY && stallModel != CMAX) stallModel++;
        if (FLUSH && flushModel != CMAX) flushModel++;
        if (outF) begin
            exp = sbQ.pop_front();
            check("out_xfer", OUT_DATA, exp);
            $display("%0t xfer out data=%h", $time, OUT_DATA);
        end
        if (FLUSH) sbQ.delete();
        else if (inF) sbQ.push_back(IN_DATA);
        accepted = inF && !FLUSH;
        @(posedge CLOCK);
        #1;
        check("out_valid", OUT_VALID, sbQ.size() != 0);
        check("in_ready", IN_READY, sbQ.size() < 2);
        if (sbQ.size() == 0) check("out_bubble", OUT_DATA, BUBBLE);
        else                 check("out_front", OUT_DATA, sbQ[0]);
`ifdef PIPE_STAGE_STATS_EN
        check("stall_cnt", STALL_CNT, stallModel);
        check("flush_cnt", FLUSH_CNT, flushModel);
`endif
    endtask

    task automatic send(input logic [DW-1:0] d);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        cycle(acc);
        IN_VALID = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #2 RESET = 1'b0;
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1;
        check("rst_valid", OUT_VALID, 1'b0);
        check("rst_data", OUT_DATA, BUBBLE);
        check("rst_ready", IN_READY, 1'b1);
        RESET = 1'b1;
        cycle(acc);

        // Streaming 1..4 back to back
        OUT_READY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = DW'(i);
            cycle(acc);
            check("stream_latency", OUT_DATA, DW'(i));
        end
        IN_VALID = 1'b0;
        repeat (2) cycle(acc);

        // Backpressure: A, B fill main and skid, C must wait
        OUT_READY = 1'b0;
        send(16'hA0A0);
        send(16'hB0B0);
        check("bp_ready_low", IN_READY, 1'b0);
        IN_VALID = 1'b1;
        IN_DATA  = 16'hC0C0;
        repeat (2) cycle(acc);
        check("bp_hold_a", OUT_DATA, 16'hA0A0);
        OUT_READY = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 8 && !acc; n++) cycle(acc);
        check("bp_c_accepted", acc, 1'b1);
        IN_VALID = 1'b0;
        repeat (3) cycle(acc);

        // Flush while FULL with a concurrent incoming payload
        OUT_READY = 1'b0;
        send(16'h1111);
        send(16'h2222);
        FLUSH    = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 16'h3333;
        cycle(acc);
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        check("flush_full_valid", OUT_VALID, 1'b0);
        OUT_READY = 1'b1;
        repeat (2) cycle(acc);

        // Flush while BUSY with out_fire in the same cycle
        OUT_READY = 1'b0;
        send(16'h4444);
        OUT_READY = 1'b1;
        FLUSH     = 1'b1;
        cycle(acc);
        FLUSH = 1'b0;
        check("flush_busy_valid", OUT_VALID, 1'b0);

        // Random traffic with occasional flushes; IN_DATA is x when idle
        for (int n = 0; n < 200; n++) begin
            IN_VALID  = ($urandom_range(0, 3) != 0);
            IN_DATA   = IN_VALID ? DW'($urandom) : 'x;
            OUT_READY = ($urandom_range(0, 2) != 0);
            FLUSH     = ($urandom_range(0, 19) == 0);
            cycle(acc);
        end
        IN_VALID = 1'b0;
        FLUSH    = 1'b0;
        IN_DATA  = '0;

        // Asynchronous reset while FULL
        OUT_READY = 1'b0;
        repeat (2) cycle(acc);
        send(16'h5555);
        send(16'h6666);
        check("pre_rst_full", IN_READY, 1'b0);
        RESET = 1'b0;
        #1;
        check("async_rst_valid", OUT_VALID, 1'b0);
        check("async_rst_data", OUT_DATA, BUBBLE);
        check("async_rst_ready", IN_READY, 1'b1);
        sbQ.delete();
        stallModel = '0;
        flushModel = '0;
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;

        // Statistics: 5 stalls and 2 flushes, then overflow the stall counter
        send(16'h7777);
        repeat (5) cycle(acc);
        OUT_READY = 1'b1;
        FLUSH     = 1'b1;
        repeat (2) cycle(acc);
        FLUSH = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
        check("stats_stall5", STALL_CNT, 3'd5);
        check("stats_flush2", FLUSH_CNT, 3'd2);
`endif
        OUT_READY = 1'b0;
        send(16'h8888);
        repeat (5) cycle(acc);
`ifdef PIPE_STAGE_STATS_EN
        check("stats_stall_sat", STALL_CNT, 3'd7);
`endif
        OUT_READY = 1'b1;
        repeat (2) cycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, misCnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor of the fixed IF/ID pipeline latch.
- Generic inter-stage register with valid/ready handshake and a 2-entry skid buffer, so stalls propagate backward as registered signals with no combinational ready path.
- Synchronous flush inserts a bubble.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with DATA_W sized per stage.

Parameters:
- DATA_W, 64, payload width (e.g. PC+4 and instruction for IF/ID).
- BUBBLE_VAL, 0, value driven on OUT_DATA when no valid entry (NOP encoding).
- CNT_W, 16, statistics counter width; used only with the optional feature.

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream has a payload.
- IN_READY  out  1  stage can accept; registered.
- IN_DATA  in  DATA_W  upstream payload.
- FLUSH  in  1  discard all held and incoming payloads.
- OUT_VALID  out  1  OUT_DATA holds a payload.
- OUT_READY  in  1  downstream accepts.
- OUT_DATA  out  DATA_W  payload to downstream; registered.

Behaviour:
- Reset (async, RESET=0):
  - State EMPTY.
  - OUT_VALID=0, OUT_DATA=BUBBLE_VAL.
  - IN_READY=1.
  - Skid contents cleared.
- Handshake definitions:
  - in_fire = IN_VALID & IN_READY.
  - out_fire = OUT_VALID & OUT_READY.
- Latency and throughput:
  - Payload accepted at edge N appears on OUT_DATA after edge N (1-cycle latency).
  - Sustained throughput is 1 payload/cycle when OUT_READY=1.
- State encoding:
  - EMPTY: main and skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: main and skid valid.
- Outputs by state:
  - OUT_VALID = (state != EMPTY).
  - IN_READY = (state != FULL). Registered, derived from the state register only.
- Transitions, EMPTY:
  - in_fire: main<=IN_DATA, go to BUSY.
- Transitions, BUSY:
  - in_fire & out_fire: main<=IN_DATA, stay in BUSY.
  - in_fire & !out_fire: skid<=IN_DATA, go to FULL.
  - !in_fire & out_fire: main<=BUBBLE_VAL, go to EMPTY.
  - Otherwise: hold.
- Transitions, FULL:
  - out_fire: main<=skid, go to BUSY.
  - Otherwise: hold all values.
- Ordering: strict FIFO; no payload is duplicated or dropped except by FLUSH.
- FLUSH (synchronous, highest priority after reset):
  - At the edge where FLUSH=1, state goes to EMPTY, main<=BUBBLE_VAL, skid cleared.
  - A payload presented with in_fire in the same cycle is discarded.
  - out_fire in that cycle still completes (downstream consumed the current main).
- While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_VALID are stable.
- IN_VALID with IN_READY=0 has no effect. Upstream holds its data, no requirement beyond that.
- Reset asserted mid-operation: immediate clear per the reset values, regardless of state.
- X on IN_DATA while IN_VALID=0 never propagates to OUT_DATA.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - Adds outputs STALL_CNT [CNT_W] and FLUSH_CNT [CNT_W].
  - STALL_CNT increments on each cycle with OUT_VALID=1 & OUT_READY=0.
  - FLUSH_CNT increments on each cycle with FLUSH=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent. Functional behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - State enum: EMPTY, BUSY, FULL.
  - Default BUBBLE_VAL (NOP = 32'h0000_0013 style constants per stage).
  - Per-stage DATA_W constants (IFID_W=64, etc.).
- Optional sub-module pipe_sat_counter (CNT_W, inc, count) instantiated twice under PIPE_STAGE_STATS_EN.
- Datapath stays in the top module.

Test Plan:
- Reset: RESET=0 mid-stream with state FULL -> immediately OUT_VALID=0, OUT_DATA=BUBBLE_VAL, IN_READY=1.
- Streaming: IN_VALID=1, data 1,2,3,4 on consecutive cycles, OUT_READY=1 -> OUT_DATA 1,2,3,4 one cycle later, no gaps.
- Backpressure: send A, B, C with OUT_READY=0 from the cycle A appears. A held on output; B in skid; IN_READY=0; C not accepted. Release OUT_READY -> A, B, C output in order, with C accepted once IN_READY=1.
- Flush: state FULL (A main, B skid), FLUSH=1 with IN_VALID=1 data C -> next cycle EMPTY, OUT_VALID=0, C never appears.
- Flush with out_fire: BUSY holding A, OUT_READY=1, FLUSH=1 -> A counted consumed, next OUT_VALID=0.
- Stats (macro on): 5 stall cycles and 2 flushes -> STALL_CNT=5, FLUSH_CNT=2. CNT_W=2 with 6 stalls -> STALL_CNT=3 (saturated).
